// File: rtl/game_link.sv
// N-player link framer: frames local DIR/SEED/START requests into checksummed UART bytes and decodes remote frames.
// TX: first byte one cycle after a request, advances only on tx_valid&&tx_ready; RX: outputs update one cycle after CHK.
module game_link #(
  parameter int         N_PLAYERS     = 2,
  parameter int         LOCAL_ID      = 0,
  parameter int         COORD_W       = 5,
  parameter int         TIMEOUT_TICKS = 8,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send,
  input  logic [1:0]             dir_local,
  input  logic                   seed_rdy,
  input  logic [COORD_W-1:0]     seed_x_in,
  input  logic [COORD_W-1:0]     seed_y_in,
  input  logic                   start_req,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [2*N_PLAYERS-1:0] dir_remote,
  output logic [N_PLAYERS-1:0]   rcvdir,
  output logic [COORD_W-1:0]     seed_x_out,
  output logic [COORD_W-1:0]     seed_y_out,
  output logic                   seed_valid,
  output logic                   start_game,
  output logic                   con_error,
  output logic [7:0]             err_cnt
);
  typedef enum logic [2:0] {T_IDLE, T_SYNC, T_HDR, T_PAY0, T_PAY1, T_CHK} tx_state_t;
  typedef enum logic [1:0] {R_HUNT, R_HDR, R_PAY, R_CHK} rx_state_t;

  localparam logic [1:0] TY_DIR   = 2'd0;
  localparam logic [1:0] TY_SEED  = 2'd1;
  localparam logic [1:0] TY_START = 2'd2;
  localparam logic [1:0] TY_RSVD  = 2'd3;
  localparam logic [1:0] LID      = 2'(LOCAL_ID);
  localparam logic [2:0] NP       = 3'(N_PLAYERS);
  localparam int         TO_W     = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_TICKS);

  tx_state_t          tx_state_q;
  logic [1:0]         cur_type_q;
  logic [3:0]         tx_seq_q;
  logic [7:0]         chk_q, tx_data_q;
  logic               tx_valid_q;
  logic               pend_start_q, pend_seed_q, pend_dir_q;
  logic [COORD_W-1:0] sx_q, sy_q;

  logic       tx_acc, chk_done, seed_lock;
  logic       pend_start_d, pend_seed_d, pend_dir_d, any_pend;
  logic [1:0] nxt_type;
  logic [7:0] hdr_byte, pay0_byte, pay1_byte;

  always_comb begin
    tx_acc       = tx_valid_q & tx_ready;
    chk_done     = tx_acc && (tx_state_q == T_CHK);
    // the frame whose CHK is leaving clears only its own request; new pulses merge
    pend_start_d = (pend_start_q | start_req) & ~(chk_done && cur_type_q == TY_START);
    pend_seed_d  = (pend_seed_q | seed_rdy) & ~(chk_done && cur_type_q == TY_SEED);
    pend_dir_d   = (pend_dir_q | send) & ~(chk_done && cur_type_q == TY_DIR);
    any_pend     = pend_start_d | pend_seed_d | pend_dir_d;
    nxt_type     = pend_start_d ? TY_START : (pend_seed_d ? TY_SEED : TY_DIR);
    seed_lock    = (tx_state_q != T_IDLE) && (cur_type_q == TY_SEED);
    hdr_byte     = {cur_type_q, LID, tx_seq_q};
    pay0_byte    = (cur_type_q == TY_SEED) ? 8'(sx_q) : {6'b0, dir_local};
    pay1_byte    = 8'(sy_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q   <= T_IDLE;
      cur_type_q   <= TY_DIR;
      tx_seq_q     <= '0;
      chk_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      pend_start_q <= 1'b0;
      pend_seed_q  <= 1'b0;
      pend_dir_q   <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
    end else begin
      pend_start_q <= pend_start_d;
      pend_seed_q  <= pend_seed_d;
      pend_dir_q   <= pend_dir_d;
      if (seed_rdy && !seed_lock) begin
        sx_q <= seed_x_in;
        sy_q <= seed_y_in;
      end
      case (tx_state_q)
        T_IDLE: if (any_pend) begin
          tx_state_q <= T_SYNC;
          cur_type_q <= nxt_type;
          tx_data_q  <= SYNC_BYTE;
          tx_valid_q <= 1'b1;
        end
        T_SYNC: if (tx_acc) begin
          tx_state_q <= T_HDR;
          tx_data_q  <= hdr_byte;
          chk_q      <= hdr_byte;
        end
        T_HDR: if (tx_acc) begin
          if (cur_type_q == TY_START) begin
            tx_state_q <= T_CHK;
            tx_data_q  <= chk_q;
          end else begin
            tx_state_q <= T_PAY0;
            tx_data_q  <= pay0_byte;
            chk_q      <= chk_q ^ pay0_byte;
          end
        end
        T_PAY0: if (tx_acc) begin
          if (cur_type_q == TY_SEED) begin
            tx_state_q <= T_PAY1;
            tx_data_q  <= pay1_byte;
            chk_q      <= chk_q ^ pay1_byte;
          end else begin
            tx_state_q <= T_CHK;
            tx_data_q  <= chk_q;
          end
        end
        T_PAY1: if (tx_acc) begin
          tx_state_q <= T_CHK;
          tx_data_q  <= chk_q;
        end
        T_CHK: if (tx_acc) begin
          tx_seq_q <= tx_seq_q + 4'd1;
          if (any_pend) begin
            tx_state_q <= T_SYNC;
            cur_type_q <= nxt_type;
            tx_data_q  <= SYNC_BYTE;
          end else begin
            tx_state_q <= T_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  rx_state_t              rx_state_q;
  logic [1:0]             rx_type_q, rx_id_q, dir_buf_q;
  logic [7:0]             rx_chk_q, err_cnt_q;
  logic                   pay_idx_q;
  logic [COORD_W-1:0]     sx_buf_q, sy_buf_q, seed_x_q, seed_y_q;
  logic [2*N_PLAYERS-1:0] dir_remote_q;
  logic [N_PLAYERS-1:0]   rcvdir_q;
  logic                   seed_valid_q, start_game_q, con_error_q;
  logic [TO_W-1:0]        to_cnt_q;

  logic hdr_bad, chk_ok, frame_ok, rejected;

  always_comb begin
    hdr_bad  = (rx_data[7:6] == TY_RSVD) || ({1'b0, rx_data[5:4]} >= NP);
    chk_ok   = (rx_data == rx_chk_q);
    frame_ok = rx_valid && (rx_state_q == R_CHK) && chk_ok && (rx_id_q != LID);
    rejected = rx_valid && (((rx_state_q == R_HDR) && hdr_bad) || ((rx_state_q == R_CHK) && !chk_ok));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q   <= R_HUNT;
      rx_type_q    <= TY_DIR;
      rx_id_q      <= '0;
      dir_buf_q    <= '0;
      rx_chk_q     <= '0;
      pay_idx_q    <= 1'b0;
      sx_buf_q     <= '0;
      sy_buf_q     <= '0;
      seed_x_q     <= '0;
      seed_y_q     <= '0;
      dir_remote_q <= '0;
      rcvdir_q     <= '0;
      seed_valid_q <= 1'b0;
      start_game_q <= 1'b0;
      con_error_q  <= 1'b0;
      err_cnt_q    <= '0;
      to_cnt_q     <= '0;
    end else begin
      rcvdir_q     <= '0;
      seed_valid_q <= 1'b0;
      start_game_q <= 1'b0;
      if (rejected && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      // a valid frame beats a coincident send tick
      if (frame_ok) begin
        to_cnt_q    <= '0;
        con_error_q <= 1'b0;
        case (rx_type_q)
          TY_DIR: for (int p = 0; p < N_PLAYERS; p++) begin
            if (rx_id_q == 2'(p)) begin
              dir_remote_q[2*p +: 2] <= dir_buf_q;
              rcvdir_q[p]            <= 1'b1;
            end
          end
          TY_SEED: begin
            seed_x_q     <= sx_buf_q;
            seed_y_q     <= sy_buf_q;
            seed_valid_q <= 1'b1;
          end
          TY_START: start_game_q <= 1'b1;
          default: ;
        endcase
      end else if (send && to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + 1'b1;
        if (to_cnt_q == TO_MAX - 1'b1) con_error_q <= 1'b1;
      end
      if (rx_valid) begin
        case (rx_state_q)
          R_HUNT: if (rx_data == SYNC_BYTE) rx_state_q <= R_HDR;
          R_HDR: begin
            if (hdr_bad) begin
              rx_state_q <= R_HUNT;
            end else begin
              rx_type_q  <= rx_data[7:6];
              rx_id_q    <= rx_data[5:4];
              rx_chk_q   <= rx_data;
              pay_idx_q  <= 1'b0;
              rx_state_q <= (rx_data[7:6] == TY_START) ? R_CHK : R_PAY;
            end
          end
          R_PAY: begin
            rx_chk_q <= rx_chk_q ^ rx_data;
            if (!pay_idx_q) begin
              dir_buf_q <= rx_data[1:0];
              sx_buf_q  <= rx_data[COORD_W-1:0];
              if (rx_type_q == TY_DIR) rx_state_q <= R_CHK;
              else                     pay_idx_q  <= 1'b1;
            end else begin
              sy_buf_q   <= rx_data[COORD_W-1:0];
              rx_state_q <= R_CHK;
            end
          end
          R_CHK:   rx_state_q <= R_HUNT;
          default: rx_state_q <= R_HUNT;
        endcase
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign dir_remote = dir_remote_q;
  assign rcvdir     = rcvdir_q;
  assign seed_x_out = seed_x_q;
  assign seed_y_out = seed_y_q;
  assign seed_valid = seed_valid_q;
  assign start_game = start_game_q;
  assign con_error  = con_error_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_game_link.sv
// Scoreboard bench for game_link: expected TX bytes and RX events are queued at stimulus time and popped by monitors.
module tb_game_link;
  localparam int NP  = 2;
  localparam int LID = 0;
  localparam int CW  = 5;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            send = 1'b0;
  logic [1:0]      dir_local = 2'd0;
  logic            seed_rdy = 1'b0;
  logic [CW-1:0]   seed_x_in = '0;
  logic [CW-1:0]   seed_y_in = '0;
  logic            start_req = 1'b0;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic [2*NP-1:0] dir_remote;
  logic [NP-1:0]   rcvdir;
  logic [CW-1:0]   seed_x_out, seed_y_out;
  logic            seed_valid, start_game, con_error;
  logic [7:0]      err_cnt;

  always #5 clk = ~clk;

  game_link #(.N_PLAYERS(NP), .LOCAL_ID(LID), .COORD_W(CW), .TIMEOUT_TICKS(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .send(send), .dir_local(dir_local), .seed_rdy(seed_rdy),
    .seed_x_in(seed_x_in), .seed_y_in(seed_y_in), .start_req(start_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .dir_remote(dir_remote), .rcvdir(rcvdir),
    .seed_x_out(seed_x_out), .seed_y_out(seed_y_out), .seed_valid(seed_valid),
    .start_game(start_game), .con_error(con_error), .err_cnt(err_cnt)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rx[$];
  logic [3:0]  seq_m = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [1:0] ty, input int npay, input logic [7:0] p0, input logic [7:0] p1);
    logic [7:0] hdr, chk;
    hdr = {ty, 2'(LID), seq_m};
    chk = hdr;
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(hdr);
    if (npay > 0) begin exp_tx.push_back(p0); chk = chk ^ p0; end
    if (npay > 1) begin exp_tx.push_back(p1); chk = chk ^ p1; end
    exp_tx.push_back(chk);
    seq_m = seq_m + 4'd1;
  endtask

  task automatic do_send(input logic [1:0] d);
    dir_local = d;
    push_tx(2'd0, 1, {6'b0, d}, 8'h00);
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] hdr, input int npay, input logic [7:0] p0,
                          input logic [7:0] p1, input logic corrupt, input logic send_on_chk);
    logic [7:0] chk;
    chk = hdr;
    rx_byte(8'hA5);
    rx_byte(hdr);
    if (npay > 0) begin rx_byte(p0); chk = chk ^ p0; end
    if (npay > 1) begin rx_byte(p1); chk = chk ^ p1; end
    if (corrupt) chk = chk ^ 8'h40;
    rx_data  = chk;
    rx_valid = 1'b1;
    if (send_on_chk) begin
      push_tx(2'd0, 1, {6'b0, dir_local}, 8'h00);
      send = 1'b1;
    end
    tick();
    rx_valid = 1'b0;
    send     = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_tx.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    check("tx_drain_left", 32'(exp_tx.size()), 32'd0);
    repeat (3) tick();
    check("tx_idle_after", 32'(tx_valid), 32'd0);
  endtask

  // TX monitor: every accepted byte must be the next queued byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst && tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_checks++;
          $display("FAIL tx_extra: got byte %h expected none", tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", 32'(tx_data), 32'(e));
        end
      end
    end
  end

  // RX monitor: every output pulse must match the next queued event
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (rst && (rcvdir != '0 || seed_valid || start_game)) begin
        if (rcvdir != '0)   act = {8'd1, 24'({rcvdir, dir_remote})};
        else if (seed_valid) act = {8'd2, 24'({seed_x_out, seed_y_out})};
        else                 act = {8'd3, 24'd0};
        if (exp_rx.size() == 0) begin
          n_checks++;
          $display("FAIL rx_extra: got event %h expected none", act);
        end else begin
          check("rx_event", act, exp_rx.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] stall_hdr;
    repeat (3) tick();
    check("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
    check("rst_dir_remote", 32'({rcvdir, dir_remote}), 32'd0);
    check("rst_seed", {20'd0, seed_valid, start_game, seed_x_out, seed_y_out}, 32'd0);
    check("rst_err", {23'd0, con_error, err_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // DIR frames, seq 0 then 1
    do_send(2'd3);
    wait_drain();
    do_send(2'd1);
    wait_drain();

    // all three requests at once: START, SEED, DIR order
    dir_local = 2'd2;
    seed_x_in = 5'd7;
    seed_y_in = 5'd19;
    push_tx(2'd2, 0, 8'h00, 8'h00);
    push_tx(2'd1, 2, 8'h07, 8'h13);
    push_tx(2'd0, 1, 8'h02, 8'h00);
    start_req = 1'b1;
    seed_rdy  = 1'b1;
    send      = 1'b1;
    tick();
    start_req = 1'b0;
    seed_rdy  = 1'b0;
    send      = 1'b0;
    wait_drain();

    // backpressure while HDR is presented
    tx_ready  = 1'b0;
    dir_local = 2'd0;
    stall_hdr = {2'b00, 2'(LID), seq_m};
    push_tx(2'd0, 1, 8'h00, 8'h00);
    send = 1'b1;
    tick();
    send     = 1'b0;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_hdr", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_hdr});
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain();

    // RX valid frames
    exp_rx.push_back({8'd1, 24'({2'b10, 4'b0100})});
    rx_frame(8'h11, 1, 8'h01, 8'h00, 1'b0, 1'b0);
    check("rcvdir_t1", 32'(rcvdir), 32'b10);
    tick();
    check("rcvdir_one_cycle", 32'(rcvdir), 32'd0);
    exp_rx.push_back({8'd1, 24'({2'b10, 4'b1100})});
    rx_frame(8'h12, 1, 8'h03, 8'h00, 1'b0, 1'b0);
    exp_rx.push_back({8'd2, 24'({5'h1C, 5'h1F})});
    rx_frame(8'h50, 2, 8'h3C, 8'hFF, 1'b0, 1'b0);
    exp_rx.push_back({8'd3, 24'd0});
    rx_frame(8'h9F, 0, 8'h00, 8'h00, 1'b0, 1'b0);

    // rejects and loopback: no events expected
    rx_frame(8'h11, 1, 8'h01, 8'h00, 1'b1, 1'b0);
    rx_frame(8'h02, 1, 8'h02, 8'h00, 1'b0, 1'b0);
    rx_byte(8'hA5);
    rx_byte(8'hD0);
    tick();
    check("err_cnt_2", 32'(err_cnt), 32'd2);
    rx_byte(8'hA5);
    rx_byte(8'h20);
    tick();
    check("err_cnt_id_range", 32'(err_cnt), 32'd3);

    // SYNC value as payload is data
    exp_rx.push_back({8'd1, 24'({2'b10, 4'b0100})});
    rx_frame(8'h13, 1, 8'hA5, 8'h00, 1'b0, 1'b0);
    check("err_cnt_hold", 32'(err_cnt), 32'd3);

    // timeout after 8 ticks without a valid frame
    for (int i = 1; i <= 9; i++) begin
      do_send(2'd1);
      if (i == 7) check("con_err_7", 32'(con_error), 32'd0);
      if (i == 8) check("con_err_8", 32'(con_error), 32'd1);
      if (i == 9) check("con_err_hold", 32'(con_error), 32'd1);
      repeat (5) tick();
    end
    wait_drain();
    exp_rx.push_back({8'd1, 24'({2'b10, 4'b1000})});
    rx_frame(8'h14, 1, 8'h02, 8'h00, 1'b0, 1'b0);
    check("con_err_clear", 32'(con_error), 32'd0);

    // send coinciding with a valid CHK leaves the counter at zero
    exp_rx.push_back({8'd1, 24'({2'b10, 4'b0000})});
    rx_frame(8'h15, 1, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (5) tick();
    for (int i = 1; i <= 8; i++) begin
      do_send(2'd2);
      if (i == 7) check("con_err_coinc_7", 32'(con_error), 32'd0);
      if (i == 8) check("con_err_coinc_8", 32'(con_error), 32'd1);
      repeat (5) tick();
    end
    wait_drain();
    check("rx_events_left", 32'(exp_rx.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
